data_bus_buffer_sync: RTL and testbench
=======================================

# data_bus_buffer_sync

Clocked, parametrised successor to the PPI's combinational data bus buffer. It synchronises the CPU's asynchronous chip-select and read/write strobes into the `clk` domain and turns CPU writes into a FIFO-buffered valid/ready stream toward the port logic. It serves CPU reads from the port logic through a registered tri-state driver. It sits between the CPU pins and the control-logic/port-register block.

## Interface
Parameters:
- `WIDTH`, 8: data bus width.
- `ADDR_W`, 2: register-select width (A1:A0).
- `DEPTH`, 4: write FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cs_n`, `rd_n`, `wr_n`  in  1 each  asynchronous CPU strobes, active-low.
- `addr`  in  ADDR_W  CPU register select.
- `bus_cpu`  inout  WIDTH  CPU data pins; high-Z unless reading.
- `wr_valid`  out  1  write entry available.
- `wr_ready`  in  1  port logic accepts entry.
- `wr_data`  out  WIDTH  FIFO head data.
- `wr_addr`  out  ADDR_W  FIFO head address.
- `rd_req`  out  1  one-cycle read request.
- `rd_addr`  out  ADDR_W  read register select.
- `rd_data`  in  WIDTH  port read data, valid in `rd_req` cycle.
- `overflow`  out  1  sticky: write lost because FIFO was full.
- `bus_err`  out  1  sticky: `rd_n` and `wr_n` both low under `cs_n` low.

## Operation
- `cs_n`, `rd_n`, `wr_n` pass through 2-flop synchronisers. `addr` and `bus_cpu` are sampled unsynchronised and must be stable when the strobe edge is detected.
- FSM states:
  - IDLE: no access.
  - WRITE: synced `cs_n` and `wr_n` low.
  - READ: synced `cs_n` and `rd_n` low.
  - ERR: both strobes low.
- Transitions:
  - IDLE→WRITE or IDLE→READ on the matching strobe pair.
  - WRITE→IDLE on synced `wr_n` rising, or `cs_n` rising. That cycle pushes {`addr`, `bus_cpu`} into the FIFO.
  - READ→IDLE on synced `rd_n` or `cs_n` rising.
  - Any→ERR when both strobes are low. ERR sets `bus_err`, performs no push or drive, and returns to IDLE only when both strobes are high.
- IDLE→READ issues `rd_req`=1 for one cycle with `rd_addr`=`addr`. The read latch captures `rd_data` in that cycle.
- In READ, `bus_cpu` is driven from the read latch. In all other states it is high-Z.
- FIFO pops when `wr_valid && wr_ready`.
  - Push while full: the entry is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both are accepted, no overflow.
- `overflow` and `bus_err` clear only on `reset`.

## Timing
- Reset values:
  - `wr_valid`=0, `rd_req`=0, `overflow`=0, `bus_err`=0.
  - `wr_data`/`wr_addr`=0, `rd_addr`=0.
  - `bus_cpu`=Z, FIFO empty, FSM=IDLE, synchronisers=1.
- Strobe edge to FSM reaction: 2 clk, from the synchroniser.
- Write:
  - `wr_valid` rises 1 clk after the push cycle, i.e. 3 clk after the pin edge.
  - CPU must hold `bus_cpu`/`addr` ≥3 clk after `wr_n` rises.
- Read:
  - `bus_cpu` is driven 1 clk after `rd_req`, i.e. 4 clk after `rd_n` falls.
  - It releases 1 clk after synced `rd_n` rises, i.e. 3 clk after the pin edge.
- FIFO is first-word-fall-through: `wr_data`/`wr_addr` valid whenever `wr_valid`. Pointers wrap modulo DEPTH.
- `reset` mid-access: the FIFO is flushed, `bus_cpu` releases to Z that cycle, and the FSM returns to IDLE. A strobe still low after reset is treated as a new access once synchronised.

## Configuration
- `DBB_READ_LATCH_EN` defined: read data is latched at `rd_req` and held for the whole READ state, as above.
- Undefined: no read latch. `bus_cpu` is driven combinationally from `rd_data` during READ, and `rd_req` stays high for the whole READ state. `rd_addr` follows `addr`.

## Structure
- Package `dbb_pkg` holds:
  - the FSM state enum (`DBB_IDLE`, `DBB_WRITE`, `DBB_READ`, `DBB_ERR`);
  - synchroniser depth constant `DBB_SYNC_STAGES`=2.
- Sub-module `dbb_fifo`: parametrised (`WIDTH+ADDR_W`, `DEPTH`) synchronous FWFT FIFO with `full`/`empty`.
- The top level holds the synchronisers, FSM, read latch and tri-state.

## Test plan
- Write 0xA5 to addr 2, `wr_ready`=1 → `wr_valid` for 1 clk with `wr_data`=0xA5, `wr_addr`=2, 3 clk after `wr_n` rises.
- Read addr 1, `rd_data`=0x3C → one `rd_req` with `rd_addr`=1. `bus_cpu`=0x3C until 3 clk after `rd_n` rises, then Z.
- `wr_ready`=0, 5 writes 0x01..0x05 (DEPTH 4) → `overflow`=1. Releasing `wr_ready` pops 0x01..0x04 in order.
- Full FIFO, 5th write in the same cycle as a pop → no overflow, 0x05 ends as the last entry.
- `rd_n` and `wr_n` both low → `bus_err`=1, no push, `bus_cpu` Z.
- `reset` during READ with 2 FIFO entries queued → `bus_cpu` Z, `wr_valid`=0 next cycle, flags 0.

Source files
------------

// File: rtl/dbb_pkg.sv
// Shared types and constants for the clocked data bus buffer.
package dbb_pkg;

  typedef enum logic [1:0] {
    DBB_IDLE,
    DBB_WRITE,
    DBB_READ,
    DBB_ERR
  } dbb_state_e;

  localparam int unsigned DBB_SYNC_STAGES = 2;

endpackage

// File: rtl/dbb_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module dbb_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             push_ok
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign push_ok = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/data_bus_buffer_sync.sv
// Clocked CPU data bus buffer: strobe synchronisers, access FSM, write FIFO, read tri-state.
// Define DBB_READ_LATCH_EN to register read data at rd_req and hold it for the whole read.
module data_bus_buffer_sync
  import dbb_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [ADDR_W-1:0] addr,
  inout  logic [WIDTH-1:0]  bus_cpu,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [WIDTH-1:0]  wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              overflow,
  output logic              bus_err
);

  logic [DBB_SYNC_STAGES-1:0] cs_sync_q, rd_sync_q, wr_sync_q;
  logic                       cs_s, rd_s, wr_s;
  dbb_state_e                 state_q, state_d;
  logic                       push, push_ok, fifo_empty, fifo_full, err_hit;
  logic                       overflow_q, bus_err_q;
  logic                       drive_en;
  logic [WIDTH-1:0]           drive_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q <= '1;
      rd_sync_q <= '1;
      wr_sync_q <= '1;
    end else begin
      cs_sync_q <= {cs_sync_q[DBB_SYNC_STAGES-2:0], cs_n};
      rd_sync_q <= {rd_sync_q[DBB_SYNC_STAGES-2:0], rd_n};
      wr_sync_q <= {wr_sync_q[DBB_SYNC_STAGES-2:0], wr_n};
    end
  end

  assign cs_s = cs_sync_q[DBB_SYNC_STAGES-1];
  assign rd_s = rd_sync_q[DBB_SYNC_STAGES-1];
  assign wr_s = wr_sync_q[DBB_SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    err_hit = !cs_s && !rd_s && !wr_s;
    unique case (state_q)
      DBB_IDLE: begin
        if (err_hit)             state_d = DBB_ERR;
        else if (!cs_s && !wr_s) state_d = DBB_WRITE;
        else if (!cs_s && !rd_s) state_d = DBB_READ;
      end
      DBB_WRITE: begin
        if (err_hit) begin
          state_d = DBB_ERR;
        end else if (cs_s || wr_s) begin
          // Write completes on the trailing edge; addr/bus_cpu are still held here.
          state_d = DBB_IDLE;
          push    = 1'b1;
        end
      end
      DBB_READ: begin
        if (err_hit)            state_d = DBB_ERR;
        else if (cs_s || rd_s)  state_d = DBB_IDLE;
      end
      DBB_ERR: begin
        if (rd_s && wr_s) state_d = DBB_IDLE;
      end
      default: state_d = DBB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DBB_IDLE;
      overflow_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_q | (push && !push_ok);
      bus_err_q  <= bus_err_q | (state_d == DBB_ERR);
    end
  end

  assign overflow = overflow_q;
  assign bus_err  = bus_err_q;

  dbb_fifo #(
    .WIDTH (WIDTH + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .din     ({addr, bus_cpu}),
    .pop     (wr_valid && wr_ready),
    .dout    ({wr_addr, wr_data}),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (push_ok)
  );

  assign wr_valid = !fifo_empty;

`ifdef DBB_READ_LATCH_EN
  logic              rd_req_q, latched_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [WIDTH-1:0]  rd_latch_q;
  logic              rd_start;

  assign rd_start = (state_q == DBB_IDLE) && (state_d == DBB_READ);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_req_q   <= 1'b0;
      latched_q  <= 1'b0;
      rd_addr_q  <= '0;
      rd_latch_q <= '0;
    end else begin
      rd_req_q  <= rd_start;
      latched_q <= (state_d == DBB_READ) && (latched_q || rd_req_q);
      if (rd_start) rd_addr_q  <= addr;
      if (rd_req_q) rd_latch_q <= rd_data;
    end
  end

  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign drive_en   = (state_q == DBB_READ) && latched_q;
  assign drive_data = rd_latch_q;
`else
  assign rd_req     = (state_q == DBB_READ);
  assign rd_addr    = addr;
  assign drive_en   = (state_q == DBB_READ);
  assign drive_data = rd_data;
`endif

  // Reset releases the bus immediately rather than waiting for the edge.
  assign bus_cpu = (drive_en && !reset) ? drive_data : 'z;

endmodule

// File: tb/tb_data_bus_buffer_sync.sv
// Directed bench for data_bus_buffer_sync with a scoreboard on the write stream.
module tb_data_bus_buffer_sync;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic              wr_ready = 1'b0;
  logic [WIDTH-1:0]  rd_data = '0;
  logic              wr_valid, rd_req, overflow, bus_err;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  wire  [WIDTH-1:0]  bus_cpu;
  logic [WIDTH-1:0]  tb_drv = '0;
  logic              tb_oe = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  // Released bus floats to all-ones through the pull-ups.
  assign bus_cpu = tb_oe ? tb_drv : 'z;
  for (genvar i = 0; i < WIDTH; i++) begin : g_pu
    pullup pu (bus_cpu[i]);
  end

  data_bus_buffer_sync #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cs_n     (cs_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .addr     (addr),
    .bus_cpu  (bus_cpu),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .wr_addr  (wr_addr),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .overflow (overflow),
    .bus_err  (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Every accepted pop must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!reset && wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {22'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      end else begin
        check("pop_data", {22'd0, wr_addr, wr_data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                           input bit expect_it, input bit pop_at_push);
    addr  = a;
    tb_drv = d;
    tb_oe = 1'b1;
    cs_n  = 1'b0;
    wr_n  = 1'b0;
    if (expect_it) exp_q.push_back({a, d});
    repeat (4) step();
    wr_n = 1'b1;
    cs_n = 1'b1;
    step();
    step();
    if (pop_at_push) wr_ready = 1'b1;
    step();
    if (pop_at_push) wr_ready = 1'b0;
    step();
    tb_oe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_wr_valid", wr_valid, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_overflow", overflow, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_wr_data", {wr_addr, wr_data}, 0);
    check("rst_bus", bus_cpu, 8'hFF);

    // Single write with ready high: wr_valid for one cycle, 3 clk after wr_n rises
    wr_ready = 1'b1;
    addr = 2'd2; tb_drv = 8'hA5; tb_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    exp_q.push_back({2'd2, 8'hA5});
    repeat (4) step();
    wr_n = 1'b1; cs_n = 1'b1;
    step();
    step();
    check("w1_valid_early", wr_valid, 0);
    step();
    check("w1_valid", wr_valid, 1);
    check("w1_data", wr_data, 8'hA5);
    check("w1_addr", wr_addr, 2);
    step();
    check("w1_valid_gone", wr_valid, 0);
    tb_oe = 1'b0;
    wr_ready = 1'b0;

    // Read addr 1
    rd_data = 8'h3C; addr = 2'd1; cs_n = 1'b0; rd_n = 1'b0;
    step();
    step();
    check("r_req_early", rd_req, 0);
    check("r_bus_early", bus_cpu, 8'hFF);
    step();
    check("r_req", rd_req, 1);
    check("r_addr", rd_addr, 1);
`ifdef DBB_READ_LATCH_EN
    check("r_bus_pre", bus_cpu, 8'hFF);
    step();
    check("r_req_pulse", rd_req, 0);
    check("r_bus", bus_cpu, 8'h3C);
`else
    check("r_bus", bus_cpu, 8'h3C);
    step();
    check("r_req_held", rd_req, 1);
`endif
    step();
    rd_n = 1'b1; cs_n = 1'b1;
    step();
    step();
    check("r_bus_hold", bus_cpu, 8'h3C);
    step();
    check("r_bus_release", bus_cpu, 8'hFF);
    check("r_no_push", wr_valid, 0);

    // Overflow: five writes into a stalled DEPTH-4 FIFO
    for (int i = 1; i <= 4; i++) cpu_write(ADDR_W'(i), WIDTH'(i), 1'b1, 1'b0);
    check("ovf_not_yet", overflow, 0);
    cpu_write(2'd1, 8'h05, 1'b0, 1'b0);
    check("ovf_set", overflow, 1);
    wr_ready = 1'b1;
    repeat (6) step();
    check("ovf_drained", wr_valid, 0);
    check("ovf_q_empty", exp_q.size(), 0);
    check("ovf_sticky", overflow, 1);
    wr_ready = 1'b0;

    // Full FIFO, push and pop in the same cycle
    do_reset();
    check("rst_clears_ovf", overflow, 0);
    for (int i = 1; i <= 4; i++) cpu_write(2'd3, WIDTH'(8'h10 + i), 1'b1, 1'b0);
    check("full_valid", wr_valid, 1);
    cpu_write(2'd0, 8'h05, 1'b1, 1'b1);
    check("pp_no_ovf", overflow, 0);
    check("pp_queue", exp_q.size(), 4);
    wr_ready = 1'b1;
    repeat (6) step();
    check("pp_drained", wr_valid, 0);
    check("pp_q_empty", exp_q.size(), 0);
    wr_ready = 1'b0;

    // Both strobes low: bus error, no push, bus released
    check("err_pre", bus_err, 0);
    rd_data = 8'h00; tb_oe = 1'b0;
    cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (4) step();
    check("err_set", bus_err, 1);
    check("err_bus", bus_cpu, 8'hFF);
    check("err_rd_req", rd_req, 0);
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (4) step();
    check("err_no_push", wr_valid, 0);
    check("err_sticky", bus_err, 1);

    // Reset during READ with two entries queued
    cpu_write(2'd0, 8'h61, 1'b1, 1'b0);
    cpu_write(2'd1, 8'h62, 1'b1, 1'b0);
    check("rr_queued", wr_valid, 1);
    rd_data = 8'h5A; addr = 2'd2; cs_n = 1'b0; rd_n = 1'b0;
    repeat (5) step();
    check("rr_bus_drv", bus_cpu, 8'h5A);
    reset = 1'b1;
    #1;
    check("rr_bus_z_now", bus_cpu, 8'hFF);
    step();
    check("rr_wr_valid", wr_valid, 0);
    check("rr_bus_err", bus_err, 0);
    check("rr_overflow", overflow, 0);
    check("rr_rd_req", rd_req, 0);
    reset = 1'b0;
    exp_q.delete();
    step();
    step();
    check("rr_req_wait", rd_req, 0);
    step();
    check("rr_req_again", rd_req, 1);
    check("rr_addr_again", rd_addr, 2);
    cs_n = 1'b1; rd_n = 1'b1;
    repeat (4) step();
    check("rr_bus_end", bus_cpu, 8'hFF);
    check("final_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
